// File: rtl/freq_gate_counter_if.sv
// Measurement bus of the frequency meter gate counter: edge pulses and enable in,
// binary/BCD result with its valid strobe out.
interface freq_gate_counter_if #(
  parameter int CNT_WIDTH = 27,
  parameter int DIGITS    = 8
);
  logic                  enable;
  logic                  pos_pulse;
  logic [CNT_WIDTH-1:0]  freq_bin;
  logic [4*DIGITS-1:0]   freq_bcd;
  logic                  overflow;
  logic                  valid;

  modport master (
    output enable, pos_pulse,
    input  freq_bin, freq_bcd, overflow, valid
  );

  modport slave (
    input  enable, pos_pulse,
    output freq_bin, freq_bcd, overflow, valid
  );
endinterface

// File: rtl/freq_gate_counter.sv
// Counts edge pulses over a fixed gate window, then converts the latched count to
// packed BCD with a sequential shift-add-3 engine and strobes the result out.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int DIGITS      = 8,
  parameter int CNT_WIDTH   = 27
) (
  input  logic               clock,
  input  logic               reset_n,
  freq_gate_counter_if.slave bus
);
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(pow10(DIGITS) - 1);
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int STEP_W = $clog2(CNT_WIDTH + 1);
  localparam int BCD_W  = 4 * DIGITS;
  localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0]    GATE_ONE  = GATE_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(CNT_WIDTH - 1);
  localparam logic [STEP_W-1:0]    STEP_ONE  = STEP_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [GATE_W-1:0]    gate_cnt_reg;
  logic [CNT_WIDTH-1:0] edge_cnt_reg;
  logic [CNT_WIDTH-1:0] capture_reg;
  logic                 capture_ovf_reg;
  logic                 gate_end;
  logic [CNT_WIDTH:0]   cap_sum;
  logic                 cap_ovf;
  logic [CNT_WIDTH-1:0] cap_val;

  state_t               state_reg, state_next;
  logic                 load_en, shift_en, done_en;
  logic [STEP_W-1:0]    step_reg;
  logic [CNT_WIDTH-1:0] bin_sh_reg;
  logic [BCD_W-1:0]     bcd_acc_reg;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W+CNT_WIDTH-1:0] shift_next;

  logic [CNT_WIDTH-1:0] freq_bin_reg;
  logic [BCD_W-1:0]     freq_bcd_reg;
  logic                 overflow_reg;
  logic                 valid_reg;

  assign gate_end = bus.enable && (gate_cnt_reg == GATE_LAST);

  // A pulse on the gate-end cycle still belongs to the closing window.
  assign cap_sum = {1'b0, edge_cnt_reg} + {{CNT_WIDTH{1'b0}}, bus.pos_pulse};
  assign cap_ovf = (cap_sum >= {1'b0, MAX_COUNT});
  assign cap_val = cap_ovf ? MAX_COUNT : cap_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gate_cnt_reg    <= '0;
      edge_cnt_reg    <= '0;
      capture_reg     <= '0;
      capture_ovf_reg <= 1'b0;
    end else begin
      if (!bus.enable || gate_end) gate_cnt_reg <= '0;
      else                         gate_cnt_reg <= gate_cnt_reg + GATE_ONE;

      if (!bus.enable || gate_end)                         edge_cnt_reg <= '0;
      else if (bus.pos_pulse && edge_cnt_reg != MAX_COUNT) edge_cnt_reg <= edge_cnt_reg + CNT_ONE;

      if (gate_end) begin
        capture_reg     <= cap_val;
        capture_ovf_reg <= cap_ovf;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gate_end) state_next = SHIFT;
      SHIFT:   if (step_reg == STEP_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_en  = (state_reg == IDLE) && gate_end;
    shift_en = (state_reg == SHIFT);
    done_en  = (state_reg == DONE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_acc_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_acc_reg[4*gi +: 4] + 4'd3 : bcd_acc_reg[4*gi +: 4];
    end
  endgenerate

  assign shift_next = {bcd_adj, bin_sh_reg} << 1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bin_sh_reg  <= '0;
      bcd_acc_reg <= '0;
      step_reg    <= '0;
    end else if (load_en) begin
      bin_sh_reg  <= cap_val;
      bcd_acc_reg <= '0;
      step_reg    <= '0;
    end else if (shift_en) begin
      {bcd_acc_reg, bin_sh_reg} <= shift_next;
      step_reg <= step_reg + STEP_ONE;
    end
  end

  // All result fields move together on the DONE edge so readers never see a mix.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freq_bin_reg <= '0;
      freq_bcd_reg <= '0;
      overflow_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg <= done_en;
      if (done_en) begin
        freq_bin_reg <= capture_reg;
        freq_bcd_reg <= bcd_acc_reg;
        overflow_reg <= capture_ovf_reg;
      end
    end
  end

  assign bus.freq_bin = freq_bin_reg;
  assign bus.freq_bcd = freq_bcd_reg;
  assign bus.overflow = overflow_reg;
  assign bus.valid    = valid_reg;

  a_start_in_idle: assert property (@(posedge clock) disable iff (!reset_n)
                                    gate_end |-> state_reg == IDLE);
endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter with a 100-cycle gate, 2 digits, 7-bit count.
module tb_freq_gate_counter;
  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int   kc;

  freq_gate_counter_if #(.CNT_WIDTH(7), .DIGITS(2)) dif ();

  freq_gate_counter #(.GATE_CYCLES(100), .DIGITS(2), .CNT_WIDTH(7)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (dif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input logic p);
    dif.pos_pulse = p;
    @(posedge clock);
    #1;
    kc++;
  endtask

  task automatic restart();
    reset_n = 1'b0;
    dif.enable = 1'b1;
    dif.pos_pulse = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    kc = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dif.enable = 1'b1;
    dif.pos_pulse = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (dif.freq_bin !== 7'd0) begin n_bad++; $display("FAIL reset_bin got=%0d want=0", dif.freq_bin); end
    n_cmp++; if (dif.freq_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_bcd got=%h want=00", dif.freq_bcd); end
    n_cmp++; if (dif.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b want=0", dif.overflow); end
    n_cmp++; if (dif.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", dif.valid); end
    $display("reset: bin=%0d bcd=%h ovf=%b valid=%b", dif.freq_bin, dif.freq_bcd, dif.overflow, dif.valid);
  endtask

  task automatic test_every_4th();
    restart();
    for (int i = 0; i < 308; i++) begin
      cyc(i < 300 && i % 4 == 0);
      n_cmp++;
      if (i >= 107 && i % 100 == 7) begin
        $display("every4 k=%0d bin=%0d bcd=%h ovf=%b", i, dif.freq_bin, dif.freq_bcd, dif.overflow);
        if ({dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow} !== {1'b1, 7'd25, 8'h25, 1'b0}) begin
          n_bad++;
          $display("FAIL every4 k=%0d got v=%b bin=%0d bcd=%h ovf=%b want v=1 bin=25 bcd=25 ovf=0",
                   i, dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow);
        end
      end else if (dif.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL every4_strobe k=%0d valid=%b want 0", i, dif.valid);
      end
    end
  endtask

  task automatic test_saturate();
    restart();
    for (int i = 0; i < 208; i++) begin
      cyc(i < 137);
      n_cmp++;
      if (i == 107) begin
        $display("sat k=%0d bin=%0d bcd=%h ovf=%b", i, dif.freq_bin, dif.freq_bcd, dif.overflow);
        if ({dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow} !== {1'b1, 7'd99, 8'h99, 1'b1}) begin
          n_bad++;
          $display("FAIL saturate got v=%b bin=%0d bcd=%h ovf=%b want v=1 bin=99 bcd=99 ovf=1",
                   dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow);
        end
      end else if (i == 207) begin
        $display("sat k=%0d bin=%0d bcd=%h ovf=%b", i, dif.freq_bin, dif.freq_bcd, dif.overflow);
        if ({dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow} !== {1'b1, 7'd37, 8'h37, 1'b0}) begin
          n_bad++;
          $display("FAIL after_sat got v=%b bin=%0d bcd=%h ovf=%b want v=1 bin=37 bcd=37 ovf=0",
                   dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow);
        end
      end else if (dif.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL sat_strobe k=%0d valid=%b want 0", i, dif.valid);
      end
    end
  endtask

  // Continues straight on from test_saturate so the zero result replaces a non-zero one.
  task automatic test_no_pulses();
    for (int i = 208; i < 408; i++) begin
      cyc(1'b0);
      n_cmp++;
      if (i % 100 == 7) begin
        $display("zero k=%0d bin=%0d bcd=%h ovf=%b", i, dif.freq_bin, dif.freq_bcd, dif.overflow);
        if ({dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow} !== {1'b1, 7'd0, 8'h00, 1'b0}) begin
          n_bad++;
          $display("FAIL no_pulses k=%0d got v=%b bin=%0d bcd=%h ovf=%b want v=1 bin=0 bcd=00 ovf=0",
                   i, dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow);
        end
      end else if (dif.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_strobe k=%0d valid=%b want 0", i, dif.valid);
      end
    end
  endtask

  task automatic test_boundary();
    restart();
    for (int i = 0; i < 208; i++) begin
      cyc(i == 99 || i == 100);
      n_cmp++;
      if (i == 107 || i == 207) begin
        $display("boundary k=%0d bin=%0d bcd=%h ovf=%b", i, dif.freq_bin, dif.freq_bcd, dif.overflow);
        if ({dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow} !== {1'b1, 7'd1, 8'h01, 1'b0}) begin
          n_bad++;
          $display("FAIL boundary k=%0d got v=%b bin=%0d bcd=%h ovf=%b want v=1 bin=1 bcd=01 ovf=0",
                   i, dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow);
        end
      end else if (dif.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL boundary_strobe k=%0d valid=%b want 0", i, dif.valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    for (int i = 0; i < 203; i++) begin
      cyc(i % 4 == 0);
      n_cmp++;
      if (i == 107) begin
        if ({dif.valid, dif.freq_bin, dif.freq_bcd} !== {1'b1, 7'd25, 8'h25}) begin
          n_bad++;
          $display("FAIL pre_abort got v=%b bin=%0d bcd=%h want v=1 bin=25 bcd=25",
                   dif.valid, dif.freq_bin, dif.freq_bcd);
        end
      end else if (dif.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL pre_abort_strobe k=%0d valid=%b want 0", i, dif.valid);
      end
    end
    reset_n = 1'b0;
    #1;
    $display("abort: bin=%0d bcd=%h ovf=%b valid=%b", dif.freq_bin, dif.freq_bcd, dif.overflow, dif.valid);
    n_cmp++;
    if ({dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow} !== 17'd0) begin
      n_bad++;
      $display("FAIL abort_clear got v=%b bin=%0d bcd=%h ovf=%b want all 0",
               dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0);
      n_cmp++;
      if (dif.valid !== 1'b0) begin n_bad++; $display("FAIL abort_hold k=%0d valid=%b want 0", i, dif.valid); end
    end
    reset_n = 1'b1;
    for (int j = 0; j < 108; j++) begin
      cyc(j < 100 && j % 4 == 0);
      n_cmp++;
      if (j == 107) begin
        $display("post_abort k=%0d bin=%0d bcd=%h ovf=%b", j, dif.freq_bin, dif.freq_bcd, dif.overflow);
        if ({dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow} !== {1'b1, 7'd25, 8'h25, 1'b0}) begin
          n_bad++;
          $display("FAIL post_abort got v=%b bin=%0d bcd=%h ovf=%b want v=1 bin=25 bcd=25 ovf=0",
                   dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow);
        end
      end else if (dif.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL post_abort_strobe k=%0d valid=%b want 0", j, dif.valid);
      end
    end
  endtask

  task automatic test_enable_gap();
    restart();
    for (int i = 0; i < 50; i++) begin
      cyc(i % 4 == 0);
      n_cmp++;
      if (dif.valid !== 1'b0) begin n_bad++; $display("FAIL gap_pre k=%0d valid=%b want 0", i, dif.valid); end
    end
    dif.enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      n_cmp++;
      if (dif.valid !== 1'b0) begin n_bad++; $display("FAIL gap_off k=%0d valid=%b want 0", i, dif.valid); end
    end
    dif.enable = 1'b1;
    for (int j = 0; j < 108; j++) begin
      cyc(j < 90 && j % 6 == 0);
      n_cmp++;
      if (j == 107) begin
        $display("gap k=%0d bin=%0d bcd=%h ovf=%b", j, dif.freq_bin, dif.freq_bcd, dif.overflow);
        if ({dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow} !== {1'b1, 7'd15, 8'h15, 1'b0}) begin
          n_bad++;
          $display("FAIL gap_result got v=%b bin=%0d bcd=%h ovf=%b want v=1 bin=15 bcd=15 ovf=0",
                   dif.valid, dif.freq_bin, dif.freq_bcd, dif.overflow);
        end
      end else if (dif.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL gap_strobe k=%0d valid=%b want 0", j, dif.valid);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    kc = 0;
    reset_n = 1'b0;
    dif.enable = 1'b0;
    dif.pos_pulse = 1'b0;
    test_reset();
    test_every_4th();
    test_saturate();
    test_no_pulses();
    test_boundary();
    test_reset_mid();
    test_enable_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
